check_slot_sched: RTL and testbench

//  Round-robin scheduler sharing one sampled-check slot (clocked check/cover monitor

---
 rtl/check_slot_sched.sv | 146 ++++++++++++++
 tb/tb_check_slot_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/check_slot_sched.sv
// rtl/check_slot_sched.sv - round-robin owner of a shared sampled-check slot
// Grants one requester a bounded enable window and counts !sig ##1 sig cover hits.
module check_slot_sched #(
  parameter int N_REQ  = 4,
  parameter int WINDOW = 8,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         test_sig,
  input  logic                     disable_i,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     en,
  output logic                     sel_sig,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic                     cov_hit,
  output logic [CNT_W-1:0]         cov_cnt
);
  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d, ptr_q, ptr_d, pick, pick_hi;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] cc_q, cc_d;
  logic             prev_q, prev_d, en_q, en_d, busy_q, busy_d;
  logic             done_q, done_d, ab_q, ab_d, hit_q, hit_d;
  logic             hi_found, stop;

  assign sel_sig = (|gnt_q) ? test_sig[owner_q] : 1'b0;
  assign stop    = disable_i || !req[owner_q];

  // First requester strictly above the pointer wins; otherwise wrap to the lowest.
  always_comb begin
    pick     = '0;
    pick_hi  = '0;
    hi_found = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        pick = OW'(j);
        if (j > int'(ptr_q)) begin
          pick_hi  = OW'(j);
          hi_found = 1'b1;
        end
      end
    end
    if (hi_found) pick = pick_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ARM;
      ARM:     state_d = stop ? DRAIN : RUN;
      RUN:     if (stop || cnt_q == '0) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    cc_d    = cc_q;
    hit_d   = 1'b0;
    en_d    = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DRAIN);
    ab_d    = (state_d == DRAIN) && disable_i;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = N_REQ'(1) << pick;
          owner_d = pick;
        end
      end
      ARM: begin
        prev_d = sel_sig;
        cnt_d  = CW'(WINDOW - 1);
      end
      RUN: begin
        prev_d = sel_sig;
        if (state_d == RUN) cnt_d = cnt_q - CW'(1);
        hit_d = !prev_q && sel_sig && !disable_i;
        if (hit_d && cc_q != '1) cc_d = cc_q + CNT_W'(1);
      end
      DRAIN: begin
        gnt_d = '0;
        ptr_d = owner_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(N_REQ - 1);
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      cc_q    <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ab_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      cc_q    <= cc_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ab_q    <= ab_d;
      hit_q   <= hit_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign en      = en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = ab_q;
  assign cov_hit = hit_q;
  assign cov_cnt = cc_q;
endmodule

// File: tb/tb_check_slot_sched.sv
// tb/tb_check_slot_sched.sv - scoreboard bench for check_slot_sched
module tb_check_slot_sched;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] test_sig;
  logic       disable_i;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       en, sel_sig, busy, done, aborted, cov_hit;
  logic [1:0] cov_cnt;

  check_slot_sched #(.N_REQ(4), .WINDOW(8), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .test_sig(test_sig), .disable_i(disable_i),
    .gnt(gnt), .owner(owner), .en(en), .sel_sig(sel_sig), .busy(busy), .done(done),
    .aborted(aborted), .cov_hit(cov_hit), .cov_cnt(cov_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int owner;
    int ab;
    int en_cycles;
    int hits;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_seen = 0;
  int   en_run = 0;
  int   hit_run = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int o, input int ab, input int enc, input int h, input int c);
    exp_t e;
    e.owner = o; e.ab = ab; e.en_cycles = enc; e.hits = h; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_seen < target && k < 200) begin
      tick();
      k++;
    end
    chk("wait_done", done_seen, target);
  endtask

  // Monitor: one scoreboard entry retired per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      en_run  = 0;
      hit_run = 0;
    end else begin
      if (en) en_run++;
      if (cov_hit) hit_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("owner", int'(owner), e.owner);
          chk("gnt_onehot", int'(gnt), 1 << e.owner);
          chk("aborted", int'(aborted), e.ab);
          chk("en_cycles", en_run, e.en_cycles);
          chk("cov_hits", hit_run, e.hits);
          chk("cov_cnt", int'(cov_cnt), e.cnt);
        end
        en_run  = 0;
        hit_run = 0;
        done_seen++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; test_sig = '0; disable_i = 1'b0;
    tick(); tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cov_cnt", int'(cov_cnt), 0);
    chk("rst_owner", int'(owner), 0);
    rst_n = 1'b1;

    // 1) all requesting: round robin 0,1,2,3,0 with full windows
    req = 4'b1111;
    for (int i = 0; i < 5; i++) push(i % 4, 0, 8, 0, 0);
    chk("gnt_before_latency", int'(gnt), 0);
    tick();
    chk("gnt_latency", int'(gnt), 1);
    chk("en_in_arm", int'(en), 0);
    chk("busy_in_arm", int'(busy), 1);
    tick();
    chk("en_in_run", int'(en), 1);
    wait_done(5);
    req = '0;

    // 2) owner 2 aborted in RUN cycle 3, then owner 3 gets the slot
    req = 4'b1100;
    push(2, 1, 3, 0, 0);
    push(3, 0, 8, 0, 0);
    tick(); tick(); tick(); tick();
    disable_i = 1'b1;
    tick();
    disable_i = 1'b0;
    wait_done(7);
    req = '0;

    // sel_sig is forced low while nothing is granted
    test_sig = 4'hF;
    #1;
    chk("sel_sig_idle", int'(sel_sig), 0);
    test_sig = '0;

    // 3) 0,1,0,1 pattern gives two hits; a rising edge under disable gives none
    req = 4'b0001;
    push(0, 0, 8, 2, 2);
    tick(); tick();
    tick(); test_sig = 4'b0001;
    tick(); test_sig = 4'b0000;
    tick(); test_sig = 4'b0001;
    wait_done(8);
    req = '0; test_sig = '0;

    req = 4'b0001;
    push(0, 1, 1, 0, 2);
    tick();
    tick(); test_sig = 4'b0001; disable_i = 1'b1;
    tick(); test_sig = 4'b0000; disable_i = 1'b0;
    wait_done(9);
    req = '0;

    // 5) requester drops during ARM: no enable, not an abort
    req = 4'b0010;
    push(1, 0, 0, 0, 2);
    tick();
    req = '0;
    wait_done(10);

    // 4) four more hits push the 2-bit counter into saturation
    req = 4'b0100;
    push(2, 0, 8, 4, 3);
    tick();
    for (int c = 1; c <= 8; c++) begin
      tick();
      test_sig = (c % 2 == 0) ? 4'b0100 : 4'b0000;
    end
    wait_done(11);
    req = '0; test_sig = '0;

    // 6) reset in the middle of RUN, then a fresh grant to requester 1
    req = 4'b1000;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_en", int'(en), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cov_cnt", int'(cov_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;
    req = 4'b0010;
    push(1, 0, 8, 0, 0);
    chk("post_rst_gnt0", int'(gnt), 0);
    tick();
    chk("post_rst_gnt", int'(gnt), 2);
    chk("post_rst_owner", int'(owner), 1);
    wait_done(12);
    req = '0;
    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
